// File: rtl/fifo_ctrl_pkg.sv
// Shared constants for the synchronous FIFO controller and its storage RAM.
package fifo_ctrl_pkg;

    // Returns the number of words addressable by an aw-bit pointer.
    function automatic int unsigned depth_of(input int unsigned aw);
        return 32'd1 << aw;
    endfunction

    localparam int unsigned FIFO_DATA_W = 6;
    localparam int unsigned FIFO_ADDR_W = 3;
    localparam int unsigned FIFO_DEPTH  = depth_of(FIFO_ADDR_W);
    localparam int unsigned FIFO_CNT_W  = FIFO_ADDR_W + 1;
    localparam int unsigned FIFO_AF_TH  = 6;
    localparam int unsigned FIFO_AE_TH  = 2;

endpackage

// File: rtl/fifo_ctrl_ram.sv
// Dual-port RAM: one write port and one registered read port.
// Read and write share a single clock edge. On an address collision, the
// read returns the word stored before the write.
module fifo_ctrl_ram
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = FIFO_DATA_W,
    parameter int unsigned ADDR_WIDTH = FIFO_ADDR_W,
    parameter int unsigned MEM_SIZE   = FIFO_DEPTH - 1
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [0:MEM_SIZE];

    // Storage array is never cleared; only the output register is reset.
    always_ff @(posedge Clock) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // The registered read port returns the word stored before any write on this edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_ctrl.sv
// Synchronous FIFO controller: pointers, occupancy, registered status flags.
// Storage sits in fifo_ctrl_ram, so popped data appears one cycle after the pop.
module fifo_ctrl
    import fifo_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH      = FIFO_DATA_W,
    parameter int unsigned ADDR_WIDTH      = FIFO_ADDR_W,
    parameter int unsigned ALMOST_FULL_TH  = FIFO_AF_TH,
    parameter int unsigned ALMOST_EMPTY_TH = FIFO_AE_TH
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iPush,
    input  logic [DATA_WIDTH-1:0] iDataIn,
    input  logic                  iPop,
    output logic [DATA_WIDTH-1:0] oDataOut,
    output logic                  oValid,
    output logic [ADDR_WIDTH:0]   oCount,
    output logic                  oFull,
    output logic                  oEmpty,
    output logic                  oAlmostFull,
    output logic                  oAlmostEmpty,
    output logic                  oOverflow,
    output logic                  oUnderflow
);

    localparam int unsigned DEPTH = depth_of(ADDR_WIDTH);
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH_C = CNT_W'(ALMOST_FULL_TH);
    localparam logic [CNT_W-1:0] AE_TH_C = CNT_W'(ALMOST_EMPTY_TH);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt_nxt;
    logic                  push_acc;
    logic                  pop_acc;
    logic                  vld_p1;

    // A full FIFO still takes a push when a pop frees a slot on the same edge.
    assign pop_acc  = iPop & ~oEmpty;
    assign push_acc = iPush & (~oFull | pop_acc);

    // Next occupancy. The flags are registered from this value, so they move with oCount.
    always_comb begin
        cnt_nxt = oCount;
        if (push_acc && !pop_acc) begin
            cnt_nxt = oCount + CNT_W'(1);
        end else if (pop_acc && !push_acc) begin
            cnt_nxt = oCount - CNT_W'(1);
        end
    end

    // Pointers, occupancy, flags and sticky error bits. Reset takes priority over push/pop.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            oCount       <= '0;
            oFull        <= 1'b0;
            oEmpty       <= 1'b1;
            oAlmostFull  <= 1'b0;
            oAlmostEmpty <= 1'b1;
            oOverflow    <= 1'b0;
            oUnderflow   <= 1'b0;
            vld_p1       <= 1'b0;
        end else begin
            if (push_acc) begin
                wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
            end
            if (pop_acc) begin
                rd_ptr <= rd_ptr + ADDR_WIDTH'(1);
            end
            oCount       <= cnt_nxt;
            oFull        <= (cnt_nxt == DEPTH_C);
            oEmpty       <= (cnt_nxt == '0);
            oAlmostFull  <= (cnt_nxt >= AF_TH_C);
            oAlmostEmpty <= (cnt_nxt <= AE_TH_C);
            if (iPush && !push_acc) begin
                oOverflow <= 1'b1;
            end
            if (iPop && !pop_acc) begin
                oUnderflow <= 1'b1;
            end
            vld_p1 <= pop_acc;
        end
    end

    assign oValid = vld_p1;

    // ---- read stage: RAM output register is oDataOut (1-cycle latency) ----
    fifo_ctrl_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .MEM_SIZE   (DEPTH - 1)
    ) u_ram (
        .Clock   (Clock),
        .Reset   (Reset),
        .wr_en   (push_acc & ~Reset),
        .wr_addr (wr_ptr),
        .wr_data (iDataIn),
        .rd_en   (pop_acc & ~Reset),
        .rd_addr (rd_ptr),
        .rd_data (oDataOut)
    );

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed bench for fifo_ctrl. The stimulus queues the expected read words,
// and a monitor on the falling edge compares each oValid beat against that queue.
module tb_fifo_ctrl;
    import fifo_ctrl_pkg::*;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       iPush = 1'b0;
    logic [5:0] iDataIn = '0;
    logic       iPop = 1'b0;
    logic [5:0] oDataOut;
    logic       oValid;
    logic [3:0] oCount;
    logic       oFull, oEmpty, oAlmostFull, oAlmostEmpty, oOverflow, oUnderflow;

    int n_chk  = 0;
    int n_pass = 0;
    logic [5:0] exp_q [$];

    fifo_ctrl dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iPush        (iPush),
        .iDataIn      (iDataIn),
        .iPop         (iPop),
        .oDataOut     (oDataOut),
        .oValid       (oValid),
        .oCount       (oCount),
        .oFull        (oFull),
        .oEmpty       (oEmpty),
        .oAlmostFull  (oAlmostFull),
        .oAlmostEmpty (oAlmostEmpty),
        .oOverflow    (oOverflow),
        .oUnderflow   (oUnderflow)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    // Monitor: every valid read beat must match the oldest queued expectation.
    always @(negedge Clock) begin
        if (oValid) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", int'(oDataOut), -1);
            end else begin
                chk("read_data", int'(oDataOut), int'(exp_q.pop_front()));
            end
        end
    end

    task automatic drive(input logic p, input logic [5:0] d, input logic q);
        iPush = p; iDataIn = d; iPop = q;
        @(posedge Clock); #1;
        iPush = 1'b0; iPop = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        Reset = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        chk("rst_count", int'(oCount), 0);
        chk("rst_empty", int'(oEmpty), 1);
        chk("rst_aempty", int'(oAlmostEmpty), 1);
        chk("rst_full", int'(oFull), 0);
        chk("rst_afull", int'(oAlmostFull), 0);
        chk("rst_valid", int'(oValid), 0);
        chk("rst_dout", int'(oDataOut), 0);
        chk("rst_ovf", int'(oOverflow), 0);
        chk("rst_unf", int'(oUnderflow), 0);
        Reset = 1'b0;

        // fill with 0x01..0x08, tracking every flag edge
        for (int k = 1; k <= 8; k++) begin
            drive(1'b1, 6'(k), 1'b0);
            chk("fill_count", int'(oCount), k);
            chk("fill_empty", int'(oEmpty), 0);
            chk("fill_afull", int'(oAlmostFull), (k >= 6) ? 1 : 0);
            chk("fill_aempty", int'(oAlmostEmpty), (k <= 2) ? 1 : 0);
            chk("fill_full", int'(oFull), (k == 8) ? 1 : 0);
        end
        chk("full_count", int'(oCount), FIFO_DEPTH);

        // push on full without pop is dropped, overflow sticks
        drive(1'b1, 6'h3F, 1'b0);
        chk("ovf_count", int'(oCount), 8);
        chk("ovf_flag", int'(oOverflow), 1);
        drive(1'b0, 6'h00, 1'b0);
        chk("ovf_sticky", int'(oOverflow), 1);
        chk("ovf_full", int'(oFull), 1);

        // push+pop while full: oldest word out, count stays at depth
        exp_q.push_back(6'h01);
        drive(1'b1, 6'h2A, 1'b1);
        chk("pp_full_count", int'(oCount), 8);
        chk("pp_full_valid", int'(oValid), 1);
        chk("pp_full_dout", int'(oDataOut), 8'h01);

        // drain: 0x02..0x08 then 0x2A, never 0x3F
        for (int k = 2; k <= 8; k++) begin
            exp_q.push_back(6'(k));
            drive(1'b0, 6'h00, 1'b1);
        end
        exp_q.push_back(6'h2A);
        drive(1'b0, 6'h00, 1'b1);
        chk("drain_count", int'(oCount), 0);
        chk("drain_empty", int'(oEmpty), 1);
        drive(1'b0, 6'h00, 1'b0);
        chk("idle_valid", int'(oValid), 0);
        chk("idle_dout_hold", int'(oDataOut), 8'h2A);

        // pop on empty: ignored, underflow sticks
        drive(1'b0, 6'h00, 1'b1);
        chk("unf_valid", int'(oValid), 0);
        chk("unf_flag", int'(oUnderflow), 1);
        chk("unf_count", int'(oCount), 0);

        // push+pop while empty: push only, no fall-through
        drive(1'b1, 6'h15, 1'b1);
        chk("pp_empty_count", int'(oCount), 1);
        chk("pp_empty_valid", int'(oValid), 0);
        exp_q.push_back(6'h15);
        drive(1'b0, 6'h00, 1'b1);
        chk("pp_empty_dout", int'(oDataOut), 8'h15);
        chk("pp_empty_cnt0", int'(oCount), 0);

        // wrap-around streaming at count 2
        drive(1'b1, 6'h20, 1'b0);
        drive(1'b1, 6'h21, 1'b0);
        chk("wrap_start_count", int'(oCount), 2);
        for (int i = 0; i < 20; i++) begin
            exp_q.push_back(6'(8'h20 + i));
            drive(1'b1, 6'(8'h22 + i), 1'b1);
            chk("wrap_count", int'(oCount), 2);
        end
        exp_q.push_back(6'h34);
        drive(1'b0, 6'h00, 1'b1);
        exp_q.push_back(6'h35);
        drive(1'b0, 6'h00, 1'b1);
        chk("wrap_end_count", int'(oCount), 0);

        // reset mid-operation, coincident with a pop
        for (int k = 0; k < 5; k++) drive(1'b1, 6'(8'h30 + k), 1'b0);
        chk("pre_rst_count", int'(oCount), 5);
        Reset = 1'b1;
        drive(1'b0, 6'h00, 1'b1);
        Reset = 1'b0;
        chk("mid_rst_valid", int'(oValid), 0);
        chk("mid_rst_count", int'(oCount), 0);
        chk("mid_rst_empty", int'(oEmpty), 1);
        chk("mid_rst_ovf", int'(oOverflow), 0);
        chk("mid_rst_unf", int'(oUnderflow), 0);
        chk("mid_rst_dout", int'(oDataOut), 0);
        drive(1'b1, 6'h0C, 1'b0);
        chk("post_rst_count", int'(oCount), 1);
        exp_q.push_back(6'h0C);
        drive(1'b0, 6'h00, 1'b1);
        chk("post_rst_dout", int'(oDataOut), 8'h0C);

        repeat (3) drive(1'b0, 6'h00, 1'b0);
        chk("queue_drained", exp_q.size(), 0);
        chk("cnt_width", $bits(oCount), FIFO_CNT_W);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
